id_ctrl_stage: RTL
==================

// Module: id_ctrl_stage
// PURPOSE
//  Registered decode/control stage of the MIPS-lite 5-stage pipeline. It sits between IF/ID and ID/EX.
//  - Decodes the opcode into the Control bundle and latches it with the operand fields into ID/EX.
//  - Detects load-use hazards, squashes wrong-path instructions after a taken branch, and drains the pipe on HALT.
//  - Keeps saturating stall and squash counters for performance readout.
// PARAMETERS
//  DATA_W       32  instruction and sign-extended immediate width
//  REG_AW       5   register address width
//  FLUSH_SLOTS  1   instructions squashed after the one in ID when branch_taken fires (0..7)
//  DRAIN_CYC    4   cycles from accepting HALT until halted asserts (>=1)
//  CNT_W        16  perf counter width
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous reset, active-low
//  in_valid     in   1        instr holds a valid fetched instruction
//  instr        in   DATA_W   Instruct: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0]
//  in_ready     out  1        ID accepts instr this cycle (comb: !stall && state==RUN)
//  branch_taken in   1        branch/jump in EX resolved taken (1-cycle pulse)
//  out_valid    out  1        ID/EX holds a real instruction (0 = bubble)
//  cntrl        out  Control  registered control bundle; all-zero on a bubble
//  dst_reg      out  REG_AW   write destination: rd for R-type, rt for I-type/ldw; 0 otherwise
//  rs_addr      out  REG_AW   registered rs field
//  rt_addr      out  REG_AW   registered rt field
//  imm_ext      out  DATA_W   sign-extended imm[15:0]
//  illegal      out  1        registered: opcode > 6'h11 (control forced all-zero)
//  stall        out  1        comb: load-use hazard this cycle
//  halted       out  1        pipeline drained after HALT; sticky until reset
//  stall_cnt    out  CNT_W    saturating count of stall cycles
//  squash_cnt   out  CNT_W    saturating count of squashed instructions
// BEHAVIOUR
//  Reset (async, rst_n=0): all registered outputs 0, state=RUN, flush_cnt=0, drain_cnt=0.
//  Decode (0x00-0x11):
//  - Add/sub/mul/or/and/xor pairs map to aluop 000..101; even opcode = reg form (rs2=1), odd = imm form (rs2=0).
//  - ldw 0x0C: wbMux=0. stw 0x0D: memWriteEnable=1. bz 0x0E: aluop=110. beq 0x0F: aluop=111, rs2=1.
//  - jr 0x10: jump=1. halt 0x11: no write.
//  - Every field is driven for every opcode; no X.
//  Latency: the instruction accepted at cycle t appears on the outputs at t+1.
//  Load-use hazard: stall=1 when all of the following hold:
//  - in_valid is 1;
//  - the current ID/EX entry is a valid ldw;
//  - its dst_reg equals instr.rs, or equals instr.rt where rt is a source (reg-form ALU, stw, beq).
//  - R0 is compared like any other register.
//  On a stall: bubble into ID/EX, in_ready=0, stall_cnt++.
//  Squash: squash=1 when branch_taken is 1 or flush_cnt!=0.
//  - A squashed accepted instruction becomes a bubble and squash_cnt++.
//  - branch_taken loads flush_cnt=FLUSH_SLOTS.
//  - flush_cnt decrements once per accepted in_valid instruction while nonzero.
//  - branch_taken and stall in the same cycle: the squash wins, stall is suppressed, and in_ready=1 (the wrong-path instr is consumed).
//  FSM ctrl_state_t {RUN, DRAIN, HALTED}:
//  - RUN: an unsquashed HALT is accepted and emitted with halt-only control; next state DRAIN, drain_cnt=DRAIN_CYC-1.
//  - DRAIN: in_ready=0; bubbles only; branch_taken is ignored; drain_cnt decrements; at 0 -> HALTED.
//  - HALTED: halted=1; in_ready=0; bubbles only; exits only through reset.
//  - A squashed HALT is a bubble and leaves the FSM in RUN.
//  Illegal opcode: out_valid=1, control all-zero, illegal=1 for that entry; no state change.
//  Counters stop at {CNT_W{1}} with no wrap-around.
//  Reset mid-DRAIN or mid-flush: everything clears immediately and the stage returns to RUN.
// STRUCTURE
//  mips_pkg holds the shared definitions:
//  - Instruct and Control structs;
//  - opcode localparams OP_ADD..OP_HALT and aluop_t;
//  - ctrl_state_t.
//  Sub-module ctrl_decode: pure combinational opcode -> Control + dst select + illegal.
//  This module owns the hazard compare, the flush/drain counters, the FSM, the ID/EX register and the perf counters.
// TESTING
//  T1 addi (0x01, rt=3, imm=16'hFFFF) -> next cycle out_valid=1, aluop=000, rs2=0, dst_reg=3, imm_ext=32'hFFFF_FFFF.
//  T2 ldw r5, then add rs=5 -> stall=1 and in_ready=0 for 1 cycle, one bubble, add issues the cycle after, stall_cnt=1.
//  T3 branch_taken together with in_valid, FLUSH_SLOTS=1 -> current and next instr squashed, third issues, squash_cnt=2.
//  T4 HALT with DRAIN_CYC=4 -> HALT emitted at t+1, in_ready=0 from t+1, halted=1 at t+4 and held for 100 cycles.
//  T5 opcode 6'h2A -> illegal=1, all control 0, out_valid=1; reset asserted mid-DRAIN -> outputs 0 and RUN.
//  T6 CNT_W=4, 20 forced stalls -> stall_cnt saturates at 4'hF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-lite decode/control stage: instruction and
// control layouts, opcode map, ALU operation codes and the control FSM states.
package mips_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_SUBI = 6'h03;
  localparam logic [5:0] OP_MUL  = 6'h04;
  localparam logic [5:0] OP_MULI = 6'h05;
  localparam logic [5:0] OP_OR   = 6'h06;
  localparam logic [5:0] OP_ORI  = 6'h07;
  localparam logic [5:0] OP_AND  = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h09;
  localparam logic [5:0] OP_XOR  = 6'h0A;
  localparam logic [5:0] OP_XORI = 6'h0B;
  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_BZ   = 6'h0E;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h11;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_BZ  = 3'd6,
    ALU_BEQ = 3'd7
  } aluop_t;

  // rd lives in imm[15:11]; it is extracted with instr_rd() rather than a field.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } Instruct;

  typedef struct packed {
    logic   regWrite;
    aluop_t aluop;
    logic   rs2;
    logic   wbMux;
    logic   memWriteEnable;
    logic   branch;
    logic   jump;
    logic   halt;
  } Control;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  function automatic logic [4:0] instr_rd(input Instruct i);
    return i.imm[15:11];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: control bundle, write-destination select,
// illegal flag and whether rt is read as a source operand.
module ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output Control     ctrl,
  output logic [4:0] dst,
  output logic       illegal,
  output logic       rt_src
);

  always_comb begin
    ctrl    = '0;
    dst     = 5'd0;
    illegal = 1'b0;
    rt_src  = 1'b0;
    // ALU pairs: opcode[3:1] selects the operation, opcode[0] picks imm form.
    if (opcode <= OP_XORI) begin
      ctrl.regWrite = 1'b1;
      ctrl.wbMux    = 1'b1;
      ctrl.aluop    = aluop_t'(opcode[3:1]);
      ctrl.rs2      = ~opcode[0];
      dst           = opcode[0] ? rt : rd;
      rt_src        = ~opcode[0];
    end else begin
      case (opcode)
        OP_LDW: begin
          ctrl.regWrite = 1'b1;
          ctrl.aluop    = ALU_ADD;
          dst           = rt;
        end
        OP_STW: begin
          ctrl.memWriteEnable = 1'b1;
          ctrl.aluop          = ALU_ADD;
          rt_src              = 1'b1;
        end
        OP_BZ: begin
          ctrl.aluop  = ALU_BZ;
          ctrl.branch = 1'b1;
        end
        OP_BEQ: begin
          ctrl.aluop  = ALU_BEQ;
          ctrl.rs2    = 1'b1;
          ctrl.branch = 1'b1;
          rt_src      = 1'b1;
        end
        OP_JR:   ctrl.jump = 1'b1;
        OP_HALT: ctrl.halt = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered ID stage of the MIPS-lite pipeline: decode into ID/EX, load-use
// stall, post-branch squash, HALT drain FSM and saturating perf counters.
module id_ctrl_stage
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int FLUSH_SLOTS = 1,
  parameter int DRAIN_CYC   = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] instr,
  output logic              in_ready,
  input  logic              branch_taken,
  output logic              out_valid,
  output Control            cntrl,
  output logic [REG_AW-1:0] dst_reg,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] imm_ext,
  output logic              illegal,
  output logic              stall,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_SLOTS);

  Instruct           ins;
  logic [REG_AW-1:0] ins_rs, ins_rt;
  Control            dec_ctrl;
  logic [4:0]        dec_dst;
  logic              dec_illegal, dec_rt_src;

  assign ins    = instr;
  assign ins_rs = REG_AW'(ins.rs);
  assign ins_rt = REG_AW'(ins.rt);

  ctrl_decode u_decode (
    .opcode  (ins.opcode),
    .rt      (ins.rt),
    .rd      (instr_rd(ins)),
    .ctrl    (dec_ctrl),
    .dst     (dec_dst),
    .illegal (dec_illegal),
    .rt_src  (dec_rt_src)
  );

  ctrl_state_t       state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic              out_valid_q, out_valid_d;
  Control            cntrl_q, cntrl_d;
  logic [REG_AW-1:0] dst_q, dst_d, rs_q, rs_d, rt_q, rt_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              illegal_q, illegal_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, squash_cnt_q, squash_cnt_d;

  logic in_run, squash, hazard, accept, issue;

  // Only regWrite with the memory writeback path identifies a load in ID/EX.
  always_comb begin
    in_run = (state_q == RUN);
    squash = in_run && (branch_taken || (flush_cnt_q != 3'd0));
    hazard = in_valid && out_valid_q && cntrl_q.regWrite && !cntrl_q.wbMux &&
             ((dst_q == ins_rs) || (dec_rt_src && (dst_q == ins_rt)));
    stall    = hazard && !squash;
    in_ready = in_run && !stall;
    accept   = in_valid && in_ready;
    issue    = accept && !squash;
  end

  always_comb begin
    out_valid_d = 1'b0;
    cntrl_d     = '0;
    dst_d       = '0;
    rs_d        = '0;
    rt_d        = '0;
    imm_d       = '0;
    illegal_d   = 1'b0;
    if (issue) begin
      out_valid_d = 1'b1;
      cntrl_d     = dec_ctrl;
      dst_d       = REG_AW'(dec_dst);
      rs_d        = ins_rs;
      rt_d        = ins_rt;
      imm_d       = {{(DATA_W-16){ins.imm[15]}}, ins.imm};
      illegal_d   = dec_illegal;
    end

    flush_cnt_d = flush_cnt_q;
    if (in_run && branch_taken)
      flush_cnt_d = FLUSH_LOAD;
    else if (accept && (flush_cnt_q != 3'd0))
      flush_cnt_d = flush_cnt_q - 3'd1;

    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (issue && dec_ctrl.halt) begin
          state_d     = (DRAIN_CYC <= 1) ? HALTED : DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // Reaching zero and entering HALTED happen on the same edge.
        if (drain_cnt_q != '0)
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        if (drain_cnt_q <= DRAIN_W'(1))
          state_d = HALTED;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);

    stall_cnt_d  = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    squash_cnt_d = (accept && squash && (squash_cnt_q != '1)) ?
                   squash_cnt_q + CNT_W'(1) : squash_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_cnt_q  <= '0;
      drain_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      cntrl_q      <= '0;
      dst_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      imm_q        <= '0;
      illegal_q    <= 1'b0;
      halted_q     <= 1'b0;
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      out_valid_q  <= out_valid_d;
      cntrl_q      <= cntrl_d;
      dst_q        <= dst_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      imm_q        <= imm_d;
      illegal_q    <= illegal_d;
      halted_q     <= halted_d;
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign cntrl      = cntrl_q;
  assign dst_reg    = dst_q;
  assign rs_addr    = rs_q;
  assign rt_addr    = rt_q;
  assign imm_ext    = imm_q;
  assign illegal    = illegal_q;
  assign halted     = halted_q;
  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;

endmodule
